// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-line memory control unit.
// Holds the op codes, the controller state set and the width helpers.
package mcu_pkg;

    typedef enum logic [1:0] {
        OP_LOAD     = 2'd0,
        OP_STORE    = 2'd1,
        OP_CHUNK_RD = 2'd2,
        OP_CHUNK_WR = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_FETCH,
        S_STORE,
        S_CHUNK_RD,
        S_CHUNK_OUT,
        S_CHUNK_WR
    } state_e;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/mcu_line_ram.sv
// DEPTH x LINE_BITS simple dual-port RAM: one write port, one registered read port.
// No reset on the array or the read register.
module mcu_line_ram #(
    parameter int LINE_BITS = 512,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [LINE_BITS-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mcu_line_ctrl.sv
// Line buffer controller: host beat streams in/out of lines, whole-line chunk transfers,
// one command at a time with done / cmd_err pulses.
module mcu_line_ctrl
    import mcu_pkg::*;
#(
    parameter int  LINE_BITS = 512,
    parameter int  HOST_BITS = 8,
    parameter int  DEPTH     = 16,
    localparam int BEATS     = LINE_BITS / HOST_BITS,
    localparam int ADDR_W    = addr_w(DEPTH),
    localparam int CNT_W     = cnt_w(BEATS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [LINE_BITS-1:0] chunk_in,
    input  logic                 host_wr_valid,
    output logic                 host_wr_ready,
    input  logic [HOST_BITS-1:0] host_wr_data,
    output logic                 host_rd_valid,
    input  logic                 host_rd_ready,
    output logic [HOST_BITS-1:0] host_rd_data,
    output logic [LINE_BITS-1:0] chunk_out,
    output logic                 chunk_out_valid,
    output logic                 done,
    output logic                 cmd_err,
    output logic                 busy
);

    if (LINE_BITS % HOST_BITS != 0) begin : g_bad_width
        $error("LINE_BITS must be a multiple of HOST_BITS");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("DEPTH must be at least 2");
    end

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [LINE_BITS-1:0]   asm_q, chunk_q, rdata;
    logic                   err_q, ram_we;
    logic                   accept, bad_addr, last, wr_hs, rd_hs;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign bad_addr  = 32'(cmd_addr) >= DEPTH;
    assign last      = (cnt_q == CNT_W'(BEATS - 1));
    assign wr_hs     = host_wr_valid && host_wr_ready;
    assign rd_hs     = host_rd_valid && host_rd_ready;
    assign cmd_err   = err_q;

    // asm_q doubles as the latched CHUNK_WR payload, so both commits share one write source.
    mcu_line_ram #(.LINE_BITS(LINE_BITS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (asm_q),
        .raddr (addr_q),
        .rdata (rdata)
    );

    assign host_rd_data = rdata[cnt_q*HOST_BITS +: HOST_BITS];
    assign chunk_out    = (state_q == S_CHUNK_OUT) ? rdata : chunk_q;

    always_comb begin
        state_d         = state_q;
        host_wr_ready   = 1'b0;
        host_rd_valid   = 1'b0;
        done            = 1'b0;
        chunk_out_valid = 1'b0;
        ram_we          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && !bad_addr) begin
                    case (op_e'(cmd_op))
                        OP_LOAD:     state_d = S_LOAD;
                        OP_STORE:    state_d = S_FETCH;
                        OP_CHUNK_RD: state_d = S_CHUNK_RD;
                        default:     state_d = S_CHUNK_WR;
                    endcase
                end
            end
            S_LOAD: begin
                host_wr_ready = 1'b1;
                if (host_wr_valid && last) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                ram_we  = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_FETCH: state_d = S_STORE;
            S_STORE: begin
                host_rd_valid = 1'b1;
                if (host_rd_ready && last) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CHUNK_RD: state_d = S_CHUNK_OUT;
            S_CHUNK_OUT: begin
                chunk_out_valid = 1'b1;
                done            = 1'b1;
                state_d         = S_IDLE;
            end
            S_CHUNK_WR: begin
                ram_we  = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            chunk_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && bad_addr;
            if (accept && !bad_addr) begin
                addr_q <= cmd_addr;
                cnt_q  <= '0;
                if (op_e'(cmd_op) == OP_CHUNK_WR) asm_q <= chunk_in;
            end
            if (wr_hs) asm_q[cnt_q*HOST_BITS +: HOST_BITS] <= host_wr_data;
            if (wr_hs || rd_hs) cnt_q <= last ? '0 : cnt_q + 1'b1;
            if (state_q == S_CHUNK_OUT) chunk_q <= rdata;
        end
    end

endmodule

// File: tb/tb_mcu_line_ctrl.sv
// Directed + randomized bench for mcu_line_ctrl (DEPTH=12) against a byte-array line model.
module tb_mcu_line_ctrl;

    localparam int LB  = 512;
    localparam int HB  = 8;
    localparam int DEP = 12;
    localparam int NB  = LB / HB;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LB-1:0] chunk_in = '0;
    logic          host_wr_valid = 1'b0, host_wr_ready;
    logic [HB-1:0] host_wr_data = '0;
    logic          host_rd_valid, host_rd_ready = 1'b0;
    logic [HB-1:0] host_rd_data;
    logic [LB-1:0] chunk_out;
    logic          chunk_out_valid, done, cmd_err, busy;

    int checks = 0;
    int failures = 0;
    byte unsigned mdl [DEP][NB];
    byte unsigned wbuf [NB];

    mcu_line_ctrl #(.LINE_BITS(LB), .HOST_BITS(HB), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .chunk_in(chunk_in),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_data(host_wr_data),
        .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready), .host_rd_data(host_rd_data),
        .chunk_out(chunk_out), .chunk_out_valid(chunk_out_valid),
        .done(done), .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LB-1:0] line_of(input int a);
        logic [LB-1:0] l;
        for (int k = 0; k < NB; k++) l[k*HB +: HB] = mdl[a][k];
        return l;
    endfunction

    function automatic logic [LB-1:0] buf_line();
        logic [LB-1:0] l;
        for (int k = 0; k < NB; k++) l[k*HB +: HB] = wbuf[k];
        return l;
    endfunction

    task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_buf(input int mode);
        for (int k = 0; k < NB; k++)
            case (mode)
                0: wbuf[k] = 8'(k);
                1: wbuf[k] = 8'hA5 ^ 8'(k);
                2: wbuf[k] = 8'hFF;
                default: wbuf[k] = 8'($urandom_range(255));
            endcase
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [LB-1:0] d);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; chunk_in = d;
        #1;
        while (!cmd_ready && n < 200) begin @(negedge clk); #1; n++; end
        chk("cmd_accept_in_time", n < 200, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input int a, input int nb, input int gap);
        int got = 0, cyc = 0;
        logic rdy_ok = 1'b1;
        issue(2'd0, AW'(a), '0);
        while (got < nb && cyc < 2000) begin
            @(negedge clk);
            host_wr_valid = (int'($urandom_range(99)) >= gap);
            host_wr_data  = wbuf[got];
            #1;
            if (!host_wr_ready) rdy_ok = 1'b0;
            if (host_wr_valid && host_wr_ready) got++;
            cyc++;
        end
        chk("load_ready_high", rdy_ok, 1'b1);
        chk("load_beats", got, nb);
        if (nb == NB) begin
            @(negedge clk); host_wr_valid = 1'b0; #1;
            chk("load_done", done, 1'b1);
            chk("load_ready_drop", host_wr_ready, 1'b0);
            for (int k = 0; k < NB; k++) mdl[a][k] = wbuf[k];
            @(negedge clk); #1;
            chk("load_done_pulse", done, 1'b0);
            chk("load_idle", cmd_ready, 1'b1);
        end
    endtask

    task automatic do_store(input int a, input int mode);
        int k = 0, cyc = 0, unstable = 0;
        logic stalled = 1'b0;
        logic [HB-1:0] prev = '0;
        issue(2'd1, AW'(a), '0);
        while (k < NB && cyc < 2000) begin
            @(negedge clk);
            host_rd_ready = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(1));
            #1;
            if (host_rd_valid) begin
                if (stalled && host_rd_data !== prev) unstable++;
                prev = host_rd_data;
                if (host_rd_ready) begin
                    chk("store_beat", host_rd_data, mdl[a][k]);
                    chk("store_done", done, k == NB - 1);
                    k++;
                    stalled = 1'b0;
                end else stalled = 1'b1;
            end
            cyc++;
        end
        chk("store_stable", unstable, 0);
        chk("store_count", k, NB);
        @(negedge clk); host_rd_ready = 1'b0; #1;
        chk("store_valid_drop", host_rd_valid, 1'b0);
        chk("store_idle", cmd_ready, 1'b1);
    endtask

    task automatic do_chunk_rd(input int a);
        issue(2'd2, AW'(a), '0);
        @(negedge clk); #1;
        chk("crd_early", chunk_out_valid, 1'b0);
        @(negedge clk); #1;
        chk("crd_valid", chunk_out_valid, 1'b1);
        chk("crd_done", done, 1'b1);
        chk("crd_data", chunk_out, line_of(a));
        @(negedge clk); #1;
        chk("crd_pulse", chunk_out_valid, 1'b0);
        chk("crd_hold", chunk_out, line_of(a));
    endtask

    task automatic do_chunk_wr(input int a);
        issue(2'd3, AW'(a), buf_line());
        @(negedge clk); #1;
        chk("cwr_done", done, 1'b1);
        for (int k = 0; k < NB; k++) mdl[a][k] = wbuf[k];
        @(negedge clk); #1;
        chk("cwr_done_pulse", done, 1'b0);
    endtask

    initial begin
        int k, cyc, early, pulses, dones, errs;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_ready", host_wr_ready, 1'b0);
        chk("rst_rd_valid", host_rd_valid, 1'b0);
        chk("rst_done", {done, cmd_err, chunk_out_valid}, 3'b000);
        chk("rst_chunk_out", chunk_out, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // LOAD a counting line, read it back as a chunk
        fill_buf(0); do_load(3, NB, 0);
        do_chunk_rd(3);

        // chunk write then stalled STORE
        fill_buf(1); do_chunk_wr(5);
        do_store(5, 0);

        // gappy LOAD
        fill_buf(3); do_load(0, NB, 40);
        do_chunk_rd(0);

        // reset mid-LOAD must not disturb the target line
        fill_buf(2); do_chunk_wr(2);
        fill_buf(3); do_load(2, 20, 0);
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_wr_ready", host_wr_ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", {done, cmd_err, chunk_out_valid, host_rd_valid}, 4'b0000);
        chk("mid_rst_chunk_out", chunk_out, '0);
        host_wr_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        do_chunk_rd(2);

        // out-of-range address
        fill_buf(3);
        issue(2'd3, AW'(13), buf_line());
        @(negedge clk); #1;
        chk("err_pulse", cmd_err, 1'b1);
        chk("err_no_done", done, 1'b0);
        chk("err_not_busy", busy, 1'b0);
        errs = 0; dones = 0;
        repeat (4) begin @(negedge clk); #1; errs += int'(cmd_err); dones += int'(done | busy); end
        chk("err_single", errs, 0);
        chk("err_quiet", dones, 0);
        do_chunk_rd(5);

        // command held during STORE is accepted once after done
        issue(2'd1, AW'(5), '0);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = AW'(3);
        k = 0; cyc = 0; early = 0;
        while (k < NB && cyc < 500) begin
            @(negedge clk); host_rd_ready = 1'b1; #1;
            if (cmd_ready) early++;
            if (host_rd_valid) begin
                chk("queue_store_beat", host_rd_data, mdl[5][k]);
                k++;
            end
            cyc++;
        end
        chk("queue_held_off", early, 0);
        @(negedge clk); #1;
        chk("queue_ready_after_done", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; host_rd_ready = 1'b0;
        pulses = 0; dones = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (chunk_out_valid) begin
                pulses++;
                chk("queue_chunk", chunk_out, line_of(3));
            end
            dones += int'(done);
        end
        chk("queue_one_chunk", pulses, 1);
        chk("queue_one_done", dones, 1);
        chk("queue_idle", busy, 1'b0);

        // randomized phase over a fully initialised buffer
        for (int a = 0; a < DEP; a++) begin fill_buf(3); do_chunk_wr(a); end
        for (int i = 0; i < 8; i++) begin
            int a;
            a = int'($urandom_range(DEP - 1));
            case ($urandom_range(3))
                0: begin fill_buf(3); do_load(a, NB, int'($urandom_range(60))); end
                1: do_store(a, 1);
                2: do_chunk_rd(a);
                default: begin fill_buf(3); do_chunk_wr(a); end
            endcase
        end
        for (int a = 0; a < DEP; a += 3) do_chunk_rd(a);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
